// File: rtl/pe_row_feeder_pkg.sv
// pe_row_feeder_pkg: shared widths, beat counts, FSM state type and tap clamp helper
package pe_row_feeder_pkg;
    localparam int DATA_W = 16;
    localparam int N_ELEM = 16;
    localparam int FLUSH_BEATS = 2;
    typedef enum logic [2:0] {IDLE, PREP, STREAM, FLUSH, DONE} feeder_state_t;
    function automatic logic [4:0] clamp_ntap(input logic [4:0] n);
        return (n > 5'd16) ? 5'd16 : n;
    endfunction
endpackage

// File: rtl/pe_row_feeder_if.sv
// pe_row_feeder_if: valid/ready buffer write port (master = SRAM read side, slave = feeder)
interface pe_row_feeder_if import pe_row_feeder_pkg::*; ();
    logic valid;
    logic ready;
    logic sel;
    logic [3:0] addr;
    logic [DATA_W-1:0] data;
    modport master(output valid, sel, addr, data, input ready);
    modport slave(input valid, sel, addr, data, output ready);
endinterface

// File: rtl/pe_row_feeder_buf.sv
// feeder_buf: 16-entry register file, one write port, one combinational read port
module feeder_buf import pe_row_feeder_pkg::*; (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [3:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [3:0]        ra,
    output logic [DATA_W-1:0] rd
);
    logic [DATA_W-1:0] mem [N_ELEM];
    // entries clear on reset, otherwise take the write
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
        else if (we) mem[wa] <= wd;
    assign rd = mem[ra];
endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: streams activation/filter beats into a 16-PE row, then flushes; PE_FEEDER_REPEAT_EN adds i_nrep back-to-back passes
module pe_row_feeder import pe_row_feeder_pkg::*; (
    input  logic              clk,
    input  logic              rstn,
    pe_row_feeder_if.slave    wr,
    input  logic [4:0]        i_ntap,
`ifdef PE_FEEDER_REPEAT_EN
    input  logic [3:0]        i_nrep,
`endif
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_en,
    output logic [DATA_W-1:0] o_r,
    output logic [DATA_W-1:0] o_f
);
    feeder_state_t state, state_n;
    logic [4:0] cnt, cnt_n, ntap_q, ntap_n;
    logic [DATA_W-1:0] act_rd, flt_rd, r_n, f_n;
    logic en_n, done_n, busy_n, ready_n, we, more, last;

    assign we = wr.valid && state == IDLE;
    assign last = cnt == 5'(N_ELEM - 1);

    feeder_buf u_act (.clk(clk), .rstn(rstn), .we(we && !wr.sel), .wa(wr.addr), .wd(wr.data), .ra(cnt[3:0]), .rd(act_rd));
    feeder_buf u_flt (.clk(clk), .rstn(rstn), .we(we && wr.sel), .wa(wr.addr), .wd(wr.data), .ra(cnt[3:0]), .rd(flt_rd));

`ifdef PE_FEEDER_REPEAT_EN
    logic [3:0] rep, nrep_q;
    assign more = rep != nrep_q;
    // pass counter restarts in PREP and advances at the end of every non-final pass
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            rep <= '0;
            nrep_q <= '0;
        end else begin
            if (state == IDLE && i_start) nrep_q <= i_nrep;
            rep <= (state == PREP) ? '0 : (state == STREAM && last && more) ? rep + 4'd1 : rep;
        end
`else
    assign more = 1'b0;
`endif

    // next state, beat counter and the values the output registers capture
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        ntap_n = ntap_q;
        case (state)
            IDLE: if (i_start) begin
                state_n = PREP;
                ntap_n = clamp_ntap(i_ntap);
            end
            PREP: begin
                state_n = STREAM;
                cnt_n = '0;
            end
            STREAM: begin
                cnt_n = last ? '0 : cnt + 5'd1;
                state_n = (last && !more) ? FLUSH : STREAM;
            end
            FLUSH: begin
                cnt_n = (cnt == 5'(FLUSH_BEATS - 1)) ? '0 : cnt + 5'd1;
                state_n = (cnt == 5'(FLUSH_BEATS - 1)) ? DONE : FLUSH;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        en_n = state == STREAM || state == FLUSH;
        r_n = (state == STREAM) ? act_rd : '0;
        f_n = (state == STREAM && cnt < ntap_q) ? flt_rd : '0;
        done_n = state == DONE;
        busy_n = state != IDLE;
        ready_n = state_n == IDLE;
    end

    // state and registered outputs; reset aborts a run with outputs forced low
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            state <= IDLE;
            cnt <= '0;
            ntap_q <= '0;
            o_en <= 1'b0;
            o_r <= '0;
            o_f <= '0;
            o_done <= 1'b0;
            o_busy <= 1'b0;
            wr.ready <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            ntap_q <= ntap_n;
            o_en <= en_n;
            o_r <= r_n;
            o_f <= f_n;
            o_done <= done_n;
            o_busy <= busy_n;
            wr.ready <= ready_n;
        end
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: randomized self-checking bench for pe_row_feeder against a beat-sequence model
module tb_pe_row_feeder;
    import pe_row_feeder_pkg::*;
    localparam int DW = DATA_W;

    logic clk, rstn, i_start, o_busy, o_done, o_en;
    logic [4:0] i_ntap;
    logic [DW-1:0] o_r, o_f;
`ifdef PE_FEEDER_REPEAT_EN
    logic [3:0] i_nrep;
`endif
    int checks, errors;
    logic [DW-1:0] act_m [16];
    logic [DW-1:0] flt_m [16];

    pe_row_feeder_if wr();

    pe_row_feeder dut (
        .clk(clk), .rstn(rstn), .wr(wr), .i_ntap(i_ntap),
`ifdef PE_FEEDER_REPEAT_EN
        .i_nrep(i_nrep),
`endif
        .i_start(i_start), .o_busy(o_busy), .o_done(o_done), .o_en(o_en), .o_r(o_r), .o_f(o_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) begin
            act_m[i] = '0;
            flt_m[i] = '0;
        end
    endtask

    task automatic wr_buf(input bit s, input int a, input logic [DW-1:0] d);
        chk("wr_ready_idle", wr.ready, 1);
        wr.valid = 1'b1; wr.sel = s; wr.addr = a[3:0]; wr.data = d;
        @(posedge clk); @(negedge clk);
        wr.valid = 1'b0;
        if (s) flt_m[a] = d; else act_m[a] = d;
    endtask

    // expected: beat i (0-based) after start edge + 2 + i; nrep+1 passes, 2 flush zeros, then done
    task automatic run(input int ntap, input int nrep, input bit dup, input bit drop);
        int ns, nb, nt, b;
        logic [DW-1:0] er, ef;
        ns = 16 * (nrep + 1);
        nb = ns + 2;
        nt = (ntap > 16) ? 16 : ntap;
        i_start = 1'b1;
        i_ntap = ntap[4:0];
`ifdef PE_FEEDER_REPEAT_EN
        i_nrep = nrep[3:0];
`endif
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        wr.valid = 1'b0;
        for (int k = 0; k <= nb + 3; k++) begin
            b = k - 2;
            er = (b >= 0 && b < ns) ? act_m[b % 16] : '0;
            ef = (b >= 0 && b < ns && (b % 16) < nt) ? flt_m[b % 16] : '0;
            chk("en", o_en, (b >= 0 && b < nb) ? 1 : 0);
            chk("r", o_r, er);
            chk("f", o_f, ef);
            chk("done", o_done, (k == 2 + nb) ? 1 : 0);
            if (k == 2 + nb) chk("busy_in_done", o_busy, 1);
            if (k == 1) chk("ready_busy", wr.ready, 0);
            i_start = (dup && k == 5) ? 1'b1 : 1'b0;
            if (drop && k == 5) begin
                wr.valid = 1'b1; wr.sel = 1'b0; wr.addr = 4'd5; wr.data = 16'd7;
            end else wr.valid = 1'b0;
            @(negedge clk);
        end
        chk("ready_after", wr.ready, 1);
        chk("busy_after", o_busy, 0);
    endtask

    initial begin
        int seen, nr;
        checks = 0; errors = 0;
        rstn = 1'b0; i_start = 1'b0; i_ntap = '0;
`ifdef PE_FEEDER_REPEAT_EN
        i_nrep = '0;
`endif
        wr.valid = 1'b0; wr.sel = 1'b0; wr.addr = '0; wr.data = '0;
        clear_model();
        repeat (2) @(negedge clk);
        chk("rst_en", o_en, 0);
        chk("rst_done", o_done, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_r", o_r, 0);
        chk("rst_f", o_f, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", wr.ready, 1);

        // 1: ramp activations, three taps
        for (int i = 0; i < 16; i++) wr_buf(0, i, DW'(i + 1));
        for (int i = 0; i < 3; i++) wr_buf(1, i, DW'(i + 1));
        run(3, 0, 0, 0);

        // 2: reset at beat 8
        i_start = 1'b1; i_ntap = 5'd16;
        @(posedge clk); @(negedge clk);
        i_start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_en_before", o_en, 1);
        rstn = 1'b0;
        #1;
        chk("mid_en", o_en, 0);
        chk("mid_r", o_r, 0);
        chk("mid_f", o_f, 0);
        chk("mid_done", o_done, 0);
        chk("mid_busy", o_busy, 0);
        clear_model();
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_done || o_en) seen = 1;
        end
        chk("no_done_after_rst", seen, 0);
        run(16, 0, 0, 0);

        // 3: write together with start, then dropped write mid-stream
        chk("wr_ready_idle", wr.ready, 1);
        wr.valid = 1'b1; wr.sel = 1'b0; wr.addr = 4'd5; wr.data = 16'd9;
        act_m[5] = 16'd9;
        run(0, 0, 0, 1);
        run(0, 0, 0, 0);

        // 4: random buffers, ntap 0 then 20
        for (int i = 0; i < 16; i++) begin
            wr_buf(0, i, DW'($urandom));
            wr_buf(1, i, DW'($urandom));
        end
        run(0, 0, 0, 0);
        run(20, 0, 0, 0);

        // 5: start pulse while busy is ignored
        run(7, 0, 1, 0);

`ifdef PE_FEEDER_REPEAT_EN
        // 6: two passes over a ramp
        for (int i = 0; i < 16; i++) wr_buf(0, i, DW'(i + 1));
        run(16, 1, 0, 0);
`endif

        // random mix of writes and runs
        for (int n = 0; n < 4; n++) begin
            for (int j = 0; j < 4; j++) wr_buf($urandom_range(0, 1), $urandom_range(0, 15), DW'($urandom));
`ifdef PE_FEEDER_REPEAT_EN
            nr = $urandom_range(0, 2);
`else
            nr = 0;
`endif
            run($urandom_range(0, 31), nr, $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
